// File: rtl/sprite_frame_player.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_frame_player
//  Purpose  : Latches the 4-bit sprite motion code once per video frame,
//             tracks the sprite's horizontal position, generates sprite ROM
//             addresses for the current VGA pixel and returns a palette index
//             plus an opaque flag to the colour mapper (fixed 2-Clk latency).
//  Ports    : Clk, Reset (async, active-high)
//             frame_tick       - one-Clk strobe at start of vertical blank
//             motion[3:0]      - [3]=right, [2]=left, [1:0]=animation frame
//             DrawX/DrawY      - current pixel column/row
//             rom_addr         - registered sprite ROM address
//             rom_data         - palette index from synchronous ROM (0=clear)
//             sprite_on        - opaque sprite pixel, 2 Clk after DrawX/DrawY
//             pixel_idx        - palette index, zero when sprite_on=0
//             sprite_x         - current sprite left column
//             facing_left      - latched direction
//  Options  : SPRITE_MIRROR_EN - ROM holds right-facing frames only; left
//             facing is produced by mirroring the column.
//  Revision : 1.0 - initial release
// ============================================================================
module sprite_frame_player #(
    parameter int SPR_W    = 32,
    parameter int SPR_H    = 48,
    parameter int SCREEN_W = 640,
    parameter int X_INIT   = 304,
    parameter int Y_POS    = 400,
    parameter int STEP     = 2,
    parameter int ADDR_W   = 14
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_tick,
    input  logic [3:0]        motion,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_data,
    output logic              sprite_on,
    output logic [3:0]        pixel_idx,
    output logic [9:0]        sprite_x,
    output logic              facing_left
);

    localparam logic signed [10:0] c_max_x       = 11'(SCREEN_W - SPR_W);
    localparam logic signed [10:0] c_step        = 11'(STEP);
    localparam logic [10:0]        c_spr_w       = 11'(SPR_W);
    localparam logic [10:0]        c_y_top       = 11'(Y_POS);
    localparam logic [10:0]        c_y_bot       = 11'(Y_POS + SPR_H);
    localparam logic [9:0]         c_y_pos       = 10'(Y_POS);
    localparam logic [9:0]         c_x_init      = 10'(X_INIT);
    localparam logic [9:0]         c_col_max     = 10'(SPR_W - 1);
    localparam logic [3:0]         c_motion_init = 4'b1000;

    // State
    logic [3:0]        cur_motion_q, cur_motion_d;
    logic [9:0]        sprite_x_q, sprite_x_d;
    logic              facing_left_q, facing_left_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              hit_d1_q, hit_d1_d;
    logic              hit_d2_q, hit_d2_d;

    // Combinational helpers
    logic signed [10:0] w_x_signed;
    logic signed [10:0] w_x_moved;
    logic               w_code_valid;
    logic [10:0]        w_dx, w_dy, w_sx, w_sx_end;
    logic               w_hit;
    logic [9:0]         w_col, w_row, w_col_eff;
    logic [2:0]         w_img;
    logic [ADDR_W-1:0]  w_addr;

    // ------------------------------------------------------------------------
    // Motion latch and horizontal movement (only on frame_tick).
    // ------------------------------------------------------------------------
    always_comb begin
        cur_motion_d  = cur_motion_q;
        sprite_x_d    = sprite_x_q;
        facing_left_d = facing_left_q;

        // Exactly one of right/left must be set for a code to be accepted.
        w_code_valid = motion[3] ^ motion[2];

        // 11-bit signed arithmetic so a left step from 0 goes negative
        // instead of wrapping, and the clamp below can catch it.
        w_x_signed = $signed({1'b0, sprite_x_q});
        w_x_moved  = motion[3] ? (w_x_signed + c_step) : (w_x_signed - c_step);

        if (frame_tick && w_code_valid) begin
            // A repeated code means "same animation frame": no step.
            if (motion != cur_motion_q) begin
                if (w_x_moved[10]) begin
                    sprite_x_d = 10'd0;
                end else if (w_x_moved > c_max_x) begin
                    sprite_x_d = c_max_x[9:0];
                end else begin
                    sprite_x_d = w_x_moved[9:0];
                end
            end
            cur_motion_d  = motion;
            facing_left_d = motion[2];
        end
    end

    // ------------------------------------------------------------------------
    // Hit test and ROM address for the current pixel.
    // ------------------------------------------------------------------------
    always_comb begin
        w_dx     = {1'b0, DrawX};
        w_dy     = {1'b0, DrawY};
        w_sx     = {1'b0, sprite_x_q};
        w_sx_end = w_sx + c_spr_w;

        w_hit = (w_dx >= w_sx) && (w_dx < w_sx_end) &&
                (w_dy >= c_y_top) && (w_dy < c_y_bot);

        // Only meaningful when w_hit=1; otherwise the address is not used.
        w_col = DrawX - sprite_x_q;
        w_row = DrawY - c_y_pos;

`ifdef SPRITE_MIRROR_EN
        w_img     = {1'b0, cur_motion_q[1:0]};
        w_col_eff = facing_left_q ? (c_col_max - w_col) : w_col;
`else
        w_img     = {facing_left_q, cur_motion_q[1:0]};
        w_col_eff = w_col;
`endif

        w_addr = ADDR_W'(w_img) * ADDR_W'(SPR_W * SPR_H)
               + ADDR_W'(w_row) * ADDR_W'(SPR_W)
               + ADDR_W'(w_col_eff);

        // Hold the last address off-sprite to avoid needless ROM toggling.
        rom_addr_d = w_hit ? w_addr : rom_addr_q;
        hit_d1_d   = w_hit;
        hit_d2_d   = hit_d1_q;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cur_motion_q  <= c_motion_init;
            sprite_x_q    <= c_x_init;
            facing_left_q <= 1'b0;
            rom_addr_q    <= '0;
            hit_d1_q      <= 1'b0;
            hit_d2_q      <= 1'b0;
        end else begin
            cur_motion_q  <= cur_motion_d;
            sprite_x_q    <= sprite_x_d;
            facing_left_q <= facing_left_d;
            rom_addr_q    <= rom_addr_d;
            hit_d1_q      <= hit_d1_d;
            hit_d2_q      <= hit_d2_d;
        end
    end

    // rom_data arrives alongside hit_d2, so the final stage is combinational.
    assign rom_addr    = rom_addr_q;
    assign sprite_x    = sprite_x_q;
    assign facing_left = facing_left_q;
    assign sprite_on   = hit_d2_q && (rom_data != 4'd0);
    assign pixel_idx   = sprite_on ? rom_data : 4'd0;

endmodule
`default_nettype wire

// File: tb/tb_sprite_frame_player.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sprite_frame_player
//  Purpose  : Self-checking bench for sprite_frame_player: motion table,
//             clamp sequences, directed pixel/address cases, reset mid-scan
//             and randomized frames/pixels against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_frame_player;

    localparam int SPR_W = 32;
    localparam int SPR_H = 48;
    localparam int Y_POS = 400;
    localparam int MAX_X = 608;

    logic        Clk;
    logic        Reset;
    logic        frame_tick;
    logic [3:0]  motion;
    logic [9:0]  DrawX, DrawY;
    logic [13:0] rom_addr;
    logic [3:0]  rom_data;
    logic        sprite_on;
    logic [3:0]  pixel_idx;
    logic [9:0]  sprite_x;
    logic        facing_left;

    sprite_frame_player dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_tick  (frame_tick),
        .motion      (motion),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .sprite_on   (sprite_on),
        .pixel_idx   (pixel_idx),
        .sprite_x    (sprite_x),
        .facing_left (facing_left)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Synchronous sprite ROM: data one Clk after address.
    logic [3:0] mem [0:16383];
    always @(posedge Clk) rom_data <= mem[rom_addr];

    int errs   = 0;
    int checks = 0;

    // Behavioural model state
    int         m_x;
    logic [3:0] m_cur;
    bit         m_face;
    int         exp_addr;

    typedef struct {
        bit valid;
        bit hit;
        int addr;
    } pix_t;
    pix_t p1, p2;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit model_hit(input int dx, input int dy);
        return (dx >= m_x) && (dx < m_x + SPR_W) && (dy >= Y_POS) && (dy < Y_POS + SPR_H);
    endfunction

    function automatic int model_addr(input int dx, input int dy);
        int col, row, img;
        col = dx - m_x;
        row = dy - Y_POS;
`ifdef SPRITE_MIRROR_EN
        img = int'(m_cur[1:0]);
        if (m_face) col = SPR_W - 1 - col;
`else
        img = int'(m_cur[1:0]) + (m_face ? 4 : 0);
`endif
        return img * SPR_W * SPR_H + row * SPR_W + col;
    endfunction

    function automatic void model_tick(input bit tk, input logic [3:0] m);
        if (tk && (m[3] != m[2])) begin
            if (m != m_cur) begin
                m_x = m_x + (m[3] ? 2 : -2);
                if (m_x < 0) m_x = 0;
                if (m_x > MAX_X) m_x = MAX_X;
            end
            m_cur  = m;
            m_face = m[2];
        end
    endfunction

    // One pixel clock: drive, advance model, step, check everything.
    task automatic cycle(input bit tk, input logic [3:0] m, input int dx, input int dy);
        pix_t cur;
        int   d;
        frame_tick = tk;
        motion     = m;
        DrawX      = 10'(dx);
        DrawY      = 10'(dy);
        cur.valid  = 1'b1;
        cur.hit    = model_hit(dx, dy);
        cur.addr   = cur.hit ? model_addr(dx, dy) : 0;
        if (cur.hit) exp_addr = cur.addr;
        p2 = p1;
        p1 = cur;
        model_tick(tk, m);
        @(posedge Clk);
        #1;
        frame_tick = 1'b0;
        check("sprite_x", 32'(sprite_x), 32'(m_x));
        check("facing_left", 32'(facing_left), 32'(m_face));
        check("rom_addr", 32'(rom_addr), 32'(exp_addr));
        if (p2.valid) begin
            d = p2.hit ? int'(mem[p2.addr]) : 0;
            check("sprite_on", 32'(sprite_on), 32'(d != 0));
            check("pixel_idx", 32'(pixel_idx), 32'(d));
        end
    endtask

    // Asserts reset asynchronously (mid-cycle) and checks the flushed state.
    task automatic do_reset();
        Reset = 1'b1;
        #1;
        check("rst_sprite_x", 32'(sprite_x), 32'd304);
        check("rst_facing", 32'(facing_left), 32'd0);
        check("rst_sprite_on", 32'(sprite_on), 32'd0);
        check("rst_pixel_idx", 32'(pixel_idx), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        @(posedge Clk);
        #1;
        Reset    = 1'b0;
        m_x      = 304;
        m_cur    = 4'b1000;
        m_face   = 1'b0;
        exp_addr = 0;
        p1       = '{1'b1, 1'b0, 0};
        p2       = '{1'b1, 1'b0, 0};
    endtask

    typedef struct {
        bit         tk;
        logic [3:0] m;
        int         ex;
        bit         ef;
    } vec_t;
    vec_t vecs [10];

    initial begin
        logic [3:0] code;
        int         base;

        vecs[0] = '{1'b1, 4'b1000, 304, 1'b0};
        vecs[1] = '{1'b1, 4'b1001, 306, 1'b0};
        vecs[2] = '{1'b1, 4'b1010, 308, 1'b0};
        vecs[3] = '{1'b1, 4'b1011, 310, 1'b0};
        vecs[4] = '{1'b1, 4'b1011, 310, 1'b0};
        vecs[5] = '{1'b1, 4'b0000, 310, 1'b0};
        vecs[6] = '{1'b1, 4'b1100, 310, 1'b0};
        vecs[7] = '{1'b0, 4'b0101, 310, 1'b0};
        vecs[8] = '{1'b1, 4'b0101, 308, 1'b1};
        vecs[9] = '{1'b1, 4'b0101, 308, 1'b1};

        for (int i = 0; i < 16384; i++) mem[i] = 4'($urandom_range(0, 15));
        Reset = 1'b0; frame_tick = 1'b0; motion = 4'b0000; DrawX = '0; DrawY = '0;
        #2;
        do_reset();

        // Motion table
        for (int i = 0; i < 10; i++) begin
            cycle(vecs[i].tk, vecs[i].m, 0, 0);
            check($sformatf("vec%0d_x", i), 32'(sprite_x), 32'(vecs[i].ex));
            check($sformatf("vec%0d_face", i), 32'(facing_left), 32'(vecs[i].ef));
        end

        // Left clamp: walk down to 2, then two more left steps
        for (int i = 0; i < 400 && m_x > 2; i++)
            cycle(1'b1, (m_cur == 4'b0101) ? 4'b0110 : 4'b0101, 0, 0);
        check("walk_to_2", 32'(sprite_x), 32'd2);
        code = (m_cur == 4'b0101) ? 4'b0110 : 4'b0101;
        cycle(1'b1, code, 0, 0);
        check("clamp_left_0", 32'(sprite_x), 32'd0);
        cycle(1'b1, (code == 4'b0101) ? 4'b0110 : 4'b0101, 0, 0);
        check("clamp_left_hold", 32'(sprite_x), 32'd0);

        // Right clamp: walk up to 606, then two more right steps
        for (int i = 0; i < 400 && m_x < 606; i++)
            cycle(1'b1, (m_cur == 4'b1001) ? 4'b1010 : 4'b1001, 0, 0);
        check("walk_to_606", 32'(sprite_x), 32'd606);
        code = (m_cur == 4'b1001) ? 4'b1010 : 4'b1001;
        cycle(1'b1, code, 0, 0);
        check("clamp_right_608", 32'(sprite_x), 32'd608);
        cycle(1'b1, (code == 4'b1001) ? 4'b1010 : 4'b1001, 0, 0);
        check("clamp_right_hold", 32'(sprite_x), 32'd608);

        // Directed pixel path, right-facing, frame 1
        do_reset();
        cycle(1'b1, 4'b1001, 0, 0);
        mem[1569] = 4'd5;
        cycle(1'b0, 4'b1001, 307, 401);
        check("addr_right", 32'(rom_addr), 32'd1569);
        cycle(1'b0, 4'b1001, 307, 401);
        check("opaque_on", 32'(sprite_on), 32'd1);
        check("opaque_idx", 32'(pixel_idx), 32'd5);
        // Reset while both pipeline stages hold hits
        do_reset();
        cycle(1'b0, 4'b0000, 0, 0);
        check("post_rst_on", 32'(sprite_on), 32'd0);

        cycle(1'b1, 4'b1001, 0, 0);
        mem[1569] = 4'd0;
        cycle(1'b0, 4'b1001, 307, 401);
        cycle(1'b0, 4'b1001, 0, 0);
        check("clear_on", 32'(sprite_on), 32'd0);
        check("clear_idx", 32'(pixel_idx), 32'd0);

        // Left-facing, frame 1
        cycle(1'b1, 4'b0101, 0, 0);
        check("left_x", 32'(sprite_x), 32'd304);
        cycle(1'b0, 4'b0101, 305, 401);
`ifdef SPRITE_MIRROR_EN
        check("addr_left", 32'(rom_addr), 32'd1598);
`else
        check("addr_left", 32'(rom_addr), 32'd7713);
`endif
        cycle(1'b0, 4'b0101, 336, 401);
        cycle(1'b0, 4'b0101, 0, 0);
        check("outside_off", 32'(sprite_on), 32'd0);

        // Tick coinciding with an active pixel: pixel uses old position
        cycle(1'b1, 4'b1010, 305, 401);
        cycle(1'b0, 4'b1010, 305, 401);
        cycle(1'b0, 4'b1010, 0, 0);

        // Randomized frames and pixels around the sprite
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            base = m_x + int'($urandom_range(0, 40)) - 4;
            if (base < 0) base = 0;
            cycle(($urandom_range(0, 3) == 0), 4'($urandom), base,
                  Y_POS - 3 + int'($urandom_range(0, 54)));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
`default_nettype wire
